// File: rtl/dma_path_responder_pkg.sv
// DMA path responder shared definitions.
// Opcodes, header field layout and FSM states.
package dma_path_responder_pkg;

  localparam logic [7:0] OP_WRITE_C = 8'h03;
  localparam logic [7:0] OP_READ_C  = 8'h01;

  localparam int HDR_OP_LSB    = 72;
  localparam int HDR_OP_W      = 8;
  localparam int HDR_LEN_LSB   = 56;
  localparam int HDR_LEN_W     = 16;
  localparam int HDR_ADDR_LSB  = 16;
  localparam int HDR_ADDR_W    = 40;
  localparam int HDR_LADDR_LSB = 0;
  localparam int HDR_LADDR_W   = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HDR,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [HDR_OP_W-1:0]    op;
    logic [HDR_LEN_W-1:0]   len;
    logic [HDR_ADDR_W-1:0]  addr;
    logic [HDR_LADDR_W-1:0] laddr;
  } hdr_t;

endpackage

// File: rtl/dma_path_responder_if.sv
// Core-side and host-side handshake bundle.
// slave = responder view, master = core/host view.
interface dma_path_responder_if;

  logic         lsc_req;
  logic         lsc_resp;
  logic         lsc_wr_valid;
  logic [127:0] lsc_wr_data;
  logic         lsc_wr_ready;
  logic         lsc_rd_valid;
  logic [127:0] lsc_rd_data;
  logic         lsc_rd_ready;
  logic         host_cmd_valid;
  logic         host_cmd_ready;
  logic         host_cmd_rwn;
  logic [39:0]  host_cmd_addr;
  logic [15:0]  host_cmd_len;
  logic [13:0]  host_cmd_laddr;
  logic         host_wr_valid;
  logic [127:0] host_wr_data;
  logic         host_wr_ready;
  logic         host_rd_valid;
  logic [127:0] host_rd_data;
  logic         host_rd_ready;

  modport slave (
    input  lsc_req, lsc_wr_valid, lsc_wr_data,
    input  lsc_rd_ready, host_cmd_ready,
    input  host_wr_ready, host_rd_valid,
    input  host_rd_data,
    output lsc_resp, lsc_wr_ready,
    output lsc_rd_valid, lsc_rd_data,
    output host_cmd_valid, host_cmd_rwn,
    output host_cmd_addr, host_cmd_len,
    output host_cmd_laddr, host_wr_valid,
    output host_wr_data, host_rd_ready
  );

  modport master (
    output lsc_req, lsc_wr_valid, lsc_wr_data,
    output lsc_rd_ready, host_cmd_ready,
    output host_wr_ready, host_rd_valid,
    output host_rd_data,
    input  lsc_resp, lsc_wr_ready,
    input  lsc_rd_valid, lsc_rd_data,
    input  host_cmd_valid, host_cmd_rwn,
    input  host_cmd_addr, host_cmd_len,
    input  host_cmd_laddr, host_wr_valid,
    input  host_wr_data, host_rd_ready
  );

endinterface

// File: rtl/dma_rd_fifo.sv
// Read-return buffer: sync FIFO, first-word-fall-through.
// Pointers and count are flushed by rst; storage is not.
module dma_rd_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign dout_o  = mem_q[rptr_q];

  // Storage write; head is read combinationally.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (rd_en) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_path_responder.sv
// Target side of the core load/store DMA link.
// Grants, parses the header, then streams write or read data.
module dma_path_responder
  import dma_path_responder_pkg::*;
#(
  parameter int         RD_FIFO_DEPTH = 8,
  parameter logic [7:0] OP_WRITE      = OP_WRITE_C,
  parameter logic [7:0] OP_READ       = OP_READ_C
) (
  input  logic                   clk,
  input  logic                   rst,
  dma_path_responder_if.slave    bus,
  output logic                   busy,
  output logic                   err_opcode
);

  state_e       state_q;
  hdr_t         hdr_q;
  hdr_t         hdr_d;
  logic         rwn_q;
  logic [15:0]  cnt_q;
  logic [15:0]  pcnt_q;
  logic         err_q;

  logic         st_hdr;
  logic         st_wr_data;
  logic         st_rd_data;
  logic         st_cmd;
  logic         rd_window;
  logic         last_w;
  logic         wr_fire;
  logic         hrdy_w;
  logic         push_w;
  logic         rd_vld_w;
  logic         pop_w;
  logic         full_w;
  logic         empty_w;
  logic [127:0] fifo_dout_w;

  assign hdr_d.op    = bus.lsc_wr_data[HDR_OP_LSB +: HDR_OP_W];
  assign hdr_d.len   = bus.lsc_wr_data[HDR_LEN_LSB +: HDR_LEN_W];
  assign hdr_d.addr  = bus.lsc_wr_data[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign hdr_d.laddr = bus.lsc_wr_data[HDR_LADDR_LSB +: HDR_LADDR_W];

  assign st_hdr     = state_q == ST_HDR;
  assign st_wr_data = state_q == ST_WR_DATA;
  assign st_rd_data = state_q == ST_RD_DATA;
  assign st_cmd     = (state_q == ST_WR_CMD) || (state_q == ST_RD_CMD);
  assign rd_window  = (state_q == ST_RD_CMD) || st_rd_data;

  assign last_w   = cnt_q == (hdr_q.len - 16'd1);
  assign wr_fire  = st_wr_data && bus.lsc_wr_valid && bus.host_wr_ready;
  assign hrdy_w   = rd_window && !full_w && (pcnt_q != hdr_q.len);
  assign push_w   = hrdy_w && bus.host_rd_valid;
  assign rd_vld_w = st_rd_data && !empty_w;
  assign pop_w    = rd_vld_w && bus.lsc_rd_ready;

  dma_rd_fifo #(
    .WIDTH (128),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_w),
    .din_i   (bus.host_rd_data),
    .pop_i   (pop_w),
    .dout_o  (fifo_dout_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  assign bus.lsc_resp       = state_q == ST_GRANT;
  assign bus.lsc_wr_ready   = st_hdr || (st_wr_data && bus.host_wr_ready);
  assign bus.host_wr_valid  = st_wr_data && bus.lsc_wr_valid;
  assign bus.host_wr_data   = st_wr_data ? bus.lsc_wr_data : '0;
  assign bus.host_cmd_valid = st_cmd;
  assign bus.host_cmd_rwn   = rwn_q;
  assign bus.host_cmd_addr  = hdr_q.addr;
  assign bus.host_cmd_len   = hdr_q.len;
  assign bus.host_cmd_laddr = hdr_q.laddr;
  assign bus.host_rd_ready  = hrdy_w;
  assign bus.lsc_rd_valid   = rd_vld_w;
  assign bus.lsc_rd_data    = rd_vld_w ? fifo_dout_w : '0;
  assign busy               = state_q != ST_IDLE;
  assign err_opcode         = err_q;

  // Transfer sequencing, header capture and beat counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      rwn_q   <= 1'b0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push_w) begin
        pcnt_q <= pcnt_q + 16'd1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (bus.lsc_req) begin
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          state_q <= ST_HDR;
        end
        ST_HDR: begin
          if (bus.lsc_wr_valid) begin
            hdr_q <= hdr_d;
            rwn_q <= hdr_d.op == OP_READ;
            if (hdr_d.op == OP_WRITE) begin
              state_q <= ST_WR_CMD;
            end else if (hdr_d.op == OP_READ) begin
              state_q <= ST_RD_CMD;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_WR_CMD: begin
          if (bus.host_cmd_ready) begin
            state_q <= (hdr_q.len == '0) ? ST_DONE : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (wr_fire) begin
            if (last_w) begin
              state_q <= ST_DONE;
            end
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RD_CMD: begin
          if (bus.host_cmd_ready) begin
            state_q <= (hdr_q.len == '0) ? ST_DONE : ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (pop_w) begin
            if (last_w) begin
              state_q <= ST_DONE;
            end
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DONE: begin
          cnt_q   <= '0;
          pcnt_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_path_responder.sv
// Directed bench for dma_path_responder.
// Hand-computed vectors; all comparisons go through chk.
module tb_dma_path_responder;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err_opcode;
  int   checks   = 0;
  int   failures = 0;

  dma_path_responder_if bus();

  dma_path_responder #(
    .RD_FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .err_opcode (err_opcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] wpat(input int i);
    return {4{32'hBEEF_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] rpat(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic grant(input string tag);
    bus.lsc_req = 1'b1;
    step();
    chk({tag, "_resp"}, bus.lsc_resp, 1'b1);
    bus.lsc_req = 1'b0;
    step();
    chk({tag, "_resp_end"}, bus.lsc_resp, 1'b0);
    chk({tag, "_hdr_rdy"}, bus.lsc_wr_ready, 1'b1);
  endtask

  task automatic send_hdr(input logic [7:0] op,
                          input logic [15:0] len,
                          input logic [39:0] addr,
                          input logic [13:0] laddr);
    bus.lsc_wr_data  = {48'hFFFF_0000_AAAA, op, len, addr, 2'b11, laddr};
    bus.lsc_wr_valid = 1'b1;
    step();
    bus.lsc_wr_valid = 1'b0;
  endtask

  task automatic cmd(input string tag,
                     input logic rwn,
                     input logic [15:0] len,
                     input logic [39:0] addr,
                     input logic [13:0] laddr);
    chk({tag, "_cmd_vld"}, bus.host_cmd_valid, 1'b1);
    chk({tag, "_cmd_rwn"}, bus.host_cmd_rwn, rwn);
    chk({tag, "_cmd_len"}, bus.host_cmd_len, len);
    chk({tag, "_cmd_addr"}, bus.host_cmd_addr, addr);
    chk({tag, "_cmd_laddr"}, bus.host_cmd_laddr, laddr);
    bus.host_cmd_ready = 1'b1;
    step();
    bus.host_cmd_ready = 1'b0;
  endtask

  task automatic do_write(input string tag,
                          input logic [15:0] len,
                          input logic [39:0] addr,
                          input logic [13:0] laddr);
    grant(tag);
    send_hdr(8'h03, len, addr, laddr);
    cmd(tag, 1'b0, len, addr, laddr);
    bus.host_wr_ready = 1'b1;
    for (int i = 0; i < int'(len); i++) begin
      bus.lsc_wr_valid = 1'b1;
      bus.lsc_wr_data  = wpat(i);
      #1;
      chk({tag, "_hw_vld"}, bus.host_wr_valid, 1'b1);
      chk({tag, "_hw_data"}, bus.host_wr_data, wpat(i));
      chk({tag, "_lw_rdy"}, bus.lsc_wr_ready, 1'b1);
      step();
    end
    bus.lsc_wr_valid = 1'b1;
    bus.lsc_wr_data  = wpat(99);
    #1;
    chk({tag, "_extra_rdy"}, bus.lsc_wr_ready, 1'b0);
    chk({tag, "_extra_hw"}, bus.host_wr_valid, 1'b0);
    chk({tag, "_done_busy"}, busy, 1'b1);
    bus.lsc_wr_valid = 1'b0;
    step();
    chk({tag, "_idle"}, busy, 1'b0);
    bus.host_wr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int rcv;
    int extra;

    rst                = 1'b1;
    bus.lsc_req        = 1'b0;
    bus.lsc_wr_valid   = 1'b0;
    bus.lsc_wr_data    = '0;
    bus.lsc_rd_ready   = 1'b0;
    bus.host_cmd_ready = 1'b0;
    bus.host_wr_ready  = 1'b0;
    bus.host_rd_valid  = 1'b0;
    bus.host_rd_data   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp", bus.lsc_resp, 1'b0);
    chk("rst_cmd", bus.host_cmd_valid, 1'b0);
    chk("rst_rdv", bus.lsc_rd_valid, 1'b0);
    chk("rst_hrdy", bus.host_rd_ready, 1'b0);
    chk("rst_lwrdy", bus.lsc_wr_ready, 1'b0);
    chk("rst_err", err_opcode, 1'b0);
    rst = 1'b0;
    step();

    // 1: write len=4
    do_write("t1", 16'd4, 40'h12_3456_7800, 14'h0010);

    // 2: read len=3, one beat at a time
    bus.lsc_rd_ready = 1'b1;
    grant("t2");
    send_hdr(8'h01, 16'd3, 40'h00_0000_1000, 14'h0020);
    chk("t2_hrdy_cmd", bus.host_rd_ready, 1'b1);
    cmd("t2", 1'b1, 16'd3, 40'h00_0000_1000, 14'h0020);
    for (int i = 0; i < 3; i++) begin
      bus.host_rd_valid = 1'b1;
      bus.host_rd_data  = rpat(100 + i);
      #1;
      chk("t2_hrdy", bus.host_rd_ready, 1'b1);
      chk("t2_pre_vld", bus.lsc_rd_valid, 1'b0);
      step();
      bus.host_rd_valid = 1'b0;
      chk("t2_rd_vld", bus.lsc_rd_valid, 1'b1);
      chk("t2_rd_data", bus.lsc_rd_data, rpat(100 + i));
      step();
    end
    chk("t2_done_vld", bus.lsc_rd_valid, 1'b0);
    chk("t2_done_busy", busy, 1'b1);
    step();
    chk("t2_idle", busy, 1'b0);

    // 3: read len=12 with core stalled for 20 cycles
    bus.lsc_rd_ready = 1'b0;
    grant("t3");
    send_hdr(8'h01, 16'd12, 40'h00_0000_2000, 14'h0030);
    cmd("t3", 1'b1, 16'd12, 40'h00_0000_2000, 14'h0030);
    sent  = 0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      bus.host_rd_valid = 1'b1;
      bus.host_rd_data  = rpat(sent);
      #1;
      if (bus.host_rd_ready) sent++;
      step();
    end
    chk("t3_sent_stall", 32'(sent), 32'd8);
    chk("t3_hrdy_full", bus.host_rd_ready, 1'b0);
    chk("t3_head_vld", bus.lsc_rd_valid, 1'b1);
    chk("t3_head", bus.lsc_rd_data, rpat(0));
    bus.lsc_rd_ready = 1'b1;
    rcv = 0;
    for (int c = 0; c < 100 && rcv < 12; c++) begin
      bus.host_rd_valid = 1'b1;
      bus.host_rd_data  = (sent < 12) ? rpat(sent) : rpat(77);
      #1;
      if (bus.host_rd_ready) begin
        if (sent < 12) sent++;
        else extra++;
      end
      if (bus.lsc_rd_valid) begin
        chk("t3_data", bus.lsc_rd_data, rpat(rcv));
        rcv++;
      end
      step();
    end
    bus.host_rd_valid = 1'b0;
    chk("t3_rcv", 32'(rcv), 32'd12);
    chk("t3_sent", 32'(sent), 32'd12);
    chk("t3_extra", 32'(extra), 32'd0);
    chk("t3_done_busy", busy, 1'b1);
    step();
    chk("t3_idle", busy, 1'b0);
    chk("t3_empty", bus.lsc_rd_valid, 1'b0);

    // 4: unknown opcode
    grant("t4");
    send_hdr(8'h7F, 16'd5, 40'h00_0000_3000, 14'h0040);
    chk("t4_err", err_opcode, 1'b1);
    chk("t4_nocmd", bus.host_cmd_valid, 1'b0);
    chk("t4_done_busy", busy, 1'b1);
    step();
    chk("t4_idle", busy, 1'b0);
    chk("t4_nocmd2", bus.host_cmd_valid, 1'b0);
    do_write("t4w", 16'd2, 40'h00_0000_4000, 14'h0050);
    chk("t4_sticky", err_opcode, 1'b1);

    // 5a: write len=0
    grant("t5a");
    send_hdr(8'h03, 16'd0, 40'h00_0000_5000, 14'h0060);
    cmd("t5a", 1'b0, 16'd0, 40'h00_0000_5000, 14'h0060);
    bus.host_wr_ready = 1'b1;
    bus.lsc_wr_valid  = 1'b1;
    bus.lsc_wr_data   = wpat(5);
    #1;
    chk("t5a_lw_rdy", bus.lsc_wr_ready, 1'b0);
    chk("t5a_hw_vld", bus.host_wr_valid, 1'b0);
    chk("t5a_done_busy", busy, 1'b1);
    bus.lsc_wr_valid = 1'b0;
    step();
    chk("t5a_idle", busy, 1'b0);

    // 5b: write len=8 with host stall
    grant("t5b");
    send_hdr(8'h03, 16'd8, 40'h00_0000_6000, 14'h0070);
    cmd("t5b", 1'b0, 16'd8, 40'h00_0000_6000, 14'h0070);
    sent = 0;
    for (int c = 0; c < 30 && sent < 8; c++) begin
      bus.host_wr_ready = !(c == 3 || c == 4);
      bus.lsc_wr_valid  = 1'b1;
      bus.lsc_wr_data   = wpat(sent);
      #1;
      chk("t5b_hw_vld", bus.host_wr_valid, 1'b1);
      chk("t5b_hw_data", bus.host_wr_data, wpat(sent));
      chk("t5b_lw_rdy", bus.lsc_wr_ready, bus.host_wr_ready);
      if (bus.host_wr_ready) sent++;
      step();
    end
    chk("t5b_sent", 32'(sent), 32'd8);
    bus.host_wr_ready = 1'b1;
    #1;
    chk("t5b_extra_rdy", bus.lsc_wr_ready, 1'b0);
    chk("t5b_done_busy", busy, 1'b1);
    bus.lsc_wr_valid = 1'b0;
    step();
    chk("t5b_idle", busy, 1'b0);
    bus.host_wr_ready = 1'b0;

    // 6: reset mid read with 2 beats buffered
    bus.lsc_rd_ready = 1'b0;
    grant("t6");
    send_hdr(8'h01, 16'd4, 40'h00_0000_7000, 14'h0080);
    cmd("t6", 1'b1, 16'd4, 40'h00_0000_7000, 14'h0080);
    for (int i = 0; i < 2; i++) begin
      bus.host_rd_valid = 1'b1;
      bus.host_rd_data  = rpat(200 + i);
      step();
    end
    bus.host_rd_valid = 1'b0;
    chk("t6_buf_vld", bus.lsc_rd_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rdv", bus.lsc_rd_valid, 1'b0);
    chk("t6_rst_rdd", bus.lsc_rd_data, 128'h0);
    chk("t6_rst_hrdy", bus.host_rd_ready, 1'b0);
    chk("t6_rst_addr", bus.host_cmd_addr, 40'h0);
    chk("t6_rst_err", err_opcode, 1'b0);
    step();
    rst = 1'b0;
    step();
    bus.lsc_rd_ready = 1'b1;
    grant("t6b");
    send_hdr(8'h01, 16'd1, 40'h00_0000_8000, 14'h0090);
    cmd("t6b", 1'b1, 16'd1, 40'h00_0000_8000, 14'h0090);
    chk("t6b_flushed", bus.lsc_rd_valid, 1'b0);
    bus.host_rd_valid = 1'b1;
    bus.host_rd_data  = rpat(300);
    step();
    bus.host_rd_valid = 1'b0;
    chk("t6b_vld", bus.lsc_rd_valid, 1'b1);
    chk("t6b_data", bus.lsc_rd_data, rpat(300));
    step();
    chk("t6b_done_busy", busy, 1'b1);
    step();
    chk("t6b_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
